// File: rtl/spi_video_ram.sv
// rtl/spi_video_ram.sv - quad-SPI SRAM frame-buffer line fetcher driving a 1-bit pixel stream
module spi_video_ram #(
    parameter int HACK_SCREEN_WIDTH  = 512,
    parameter int HACK_SCREEN_HEIGHT = 256,
    parameter int SCK_DIV            = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       initialized,
    input  logic       display_trigger_read,
    input  logic       display_active,
    input  logic [9:0] display_hpos,
    input  logic [9:0] display_vpos,
    output logic       pixel_out,
    output logic       sram_cs_n,
    output logic       sram_sck,
    output logic       sram_sio_oe,
    input  logic       sram_sio0_i,
    input  logic       sram_sio1_i,
    input  logic       sram_sio2_i,
    input  logic       sram_sio3_i,
    output logic       sram_sio0_o,
    output logic       sram_sio1_o,
    output logic       sram_sio2_o,
    output logic       sram_sio3_o
);
    localparam int CMD_CYC    = 8 * SCK_DIV;
    localparam int GAP_CYC    = 4;
    localparam int DUMMY_CYC  = 2 * SCK_DIV;
    localparam int DATA_CYC   = (HACK_SCREEN_WIDTH / 4) * SCK_DIV;
    localparam int RD_CYC     = CMD_CYC + DUMMY_CYC + DATA_CYC;
    localparam int CW         = $clog2(RD_CYC + 1);
    localparam int ADDR_SHIFT = $clog2(HACK_SCREEN_WIDTH / 8);

    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(CMD_CYC + GAP_CYC - 1);
    localparam logic [CW-1:0] DUMMY_LAST = CW'(CMD_CYC + DUMMY_CYC - 1);
    localparam logic [CW-1:0] DATA_BASE  = CW'(CMD_CYC + DUMMY_CYC);
    localparam logic [CW-1:0] RD_LAST    = CW'(RD_CYC - 1);
    localparam logic [CW-1:0] DIV_W      = CW'(SCK_DIV);
    localparam logic [CW-1:0] HALF_W     = CW'(SCK_DIV / 2);
    localparam logic [9:0]    HEIGHT_L   = 10'(HACK_SCREEN_HEIGHT);
    localparam logic [9:0]    WIDTH_L    = 10'(HACK_SCREEN_WIDTH);
    localparam logic [9:0]    LAST_VPOS  = 10'd524;
    localparam logic [7:0]    EQIO_CMD   = 8'h38;
    localparam logic [7:0]    READ_CMD   = 8'h03;

    typedef enum logic [2:0] {
        INIT_CMD,
        INIT_GAP,
        IDLE,
        RD_CMD,
        RD_DUMMY,
        RD_DATA
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          live;
    logic          init_nxt;
    logic [9:0]    line_q;
    logic [9:0]    line_nxt;
    logic [9:0]    target_line;
    logic          start;
    logic          vis;
    logic          sck_hi;
    logic          sample_now;
    logic [2:0]    slot;
    logic [23:0]   rd_addr;
    logic [31:0]   rd_word;
    logic [CW-1:0] data_off;
    logic [1:0]    data_slot;
    logic [3:0]    sio_in;
    logic [3:0]    pix_nib;
    logic          cs_n_c;
    logic          sck_c;
    logic          oe_c;
    logic [3:0]    sio_c;
    logic [3:0]    nib_mem [4];

    assign target_line = (display_vpos == LAST_VPOS) ? 10'd0 : display_vpos + 10'd1;
    assign start       = initialized && display_trigger_read && (target_line < HEIGHT_L);
    assign vis         = display_active && (display_vpos < HEIGHT_L) && initialized;

    // cnt is the cycle position inside the current init or read sequence
    assign sck_hi     = (cnt % DIV_W) >= HALF_W;
    assign sample_now = (state == RD_DATA) && ((cnt % DIV_W) == HALF_W);
    assign slot       = 3'(cnt / DIV_W);
    assign rd_addr    = 24'(line_q) << ADDR_SHIFT;
    assign rd_word    = {READ_CMD, rd_addr};
    assign data_off   = cnt - DATA_BASE;
    assign data_slot  = 2'(data_off / DIV_W);
    assign sio_in     = {sram_sio3_i, sram_sio2_i, sram_sio1_i, sram_sio0_i};

    // live holds the sequencer still until the first clock after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= INIT_CMD;
            cnt         <= '0;
            live        <= 1'b0;
            initialized <= 1'b0;
            line_q      <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            live        <= 1'b1;
            initialized <= init_nxt;
            line_q      <= line_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        init_nxt  = initialized;
        line_nxt  = line_q;
        if (live) begin
            case (state)
                INIT_CMD: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CMD_LAST) state_nxt = INIT_GAP;
                end
                INIT_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        init_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (start) begin
                        state_nxt = RD_CMD;
                        cnt_nxt   = '0;
                        line_nxt  = target_line;
                    end
                end
                RD_CMD: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CMD_LAST) state_nxt = RD_DUMMY;
                end
                RD_DUMMY: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == DUMMY_LAST) state_nxt = RD_DATA;
                end
                RD_DATA: begin
                    if (cnt == RD_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        cs_n_c = 1'b1;
        sck_c  = 1'b0;
        oe_c   = 1'b0;
        sio_c  = 4'b0000;
        if (live) begin
            case (state)
                INIT_CMD: begin
                    cs_n_c = 1'b0;
                    sck_c  = sck_hi;
                    oe_c   = 1'b1;
                    sio_c  = {2'b11, 1'b0, EQIO_CMD[3'd7 - slot]};
                end
                RD_CMD: begin
                    cs_n_c = 1'b0;
                    sck_c  = sck_hi;
                    oe_c   = 1'b1;
                    sio_c  = rd_word[5'd31 - {slot, 2'b00} -: 4];
                end
                RD_DUMMY, RD_DATA: begin
                    cs_n_c = 1'b0;
                    sck_c  = sck_hi;
                end
                default: begin
                    cs_n_c = 1'b1;
                end
            endcase
        end
    end

    // A 4-deep nibble ring is enough: nibble k is shown well before nibble k+4 lands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) nib_mem[i] <= 4'h0;
        end else if (live && sample_now) begin
            nib_mem[data_slot] <= sio_in;
        end
    end

    assign pix_nib   = nib_mem[display_hpos[3:2]];
    assign pixel_out = vis && (display_hpos < WIDTH_L) && pix_nib[~display_hpos[1:0]];

    assign sram_cs_n   = cs_n_c;
    assign sram_sck    = sck_c;
    assign sram_sio_oe = oe_c && !vis;
    assign sram_sio0_o = sio_c[0];
    assign sram_sio1_o = sio_c[1];
    assign sram_sio2_o = sio_c[2];
    assign sram_sio3_o = sio_c[3];
endmodule

// File: tb/tb_spi_video_ram.sv
// tb/tb_spi_video_ram.sv - randomized bench for spi_video_ram with SRAM and pixel reference models
module tb_spi_video_ram;
    logic       clk;
    logic       reset;
    logic       initialized;
    logic       display_trigger_read;
    logic       display_active;
    logic [9:0] display_hpos;
    logic [9:0] display_vpos;
    logic       pixel_out;
    logic       sram_cs_n;
    logic       sram_sck;
    logic       sram_sio_oe;
    logic [3:0] sio_i;
    logic       sram_sio0_o;
    logic       sram_sio1_o;
    logic       sram_sio2_o;
    logic       sram_sio3_o;

    int n_checks = 0;
    int n_pass   = 0;

    spi_video_ram dut (
        .clk                  (clk),
        .reset                (reset),
        .initialized          (initialized),
        .display_trigger_read (display_trigger_read),
        .display_active       (display_active),
        .display_hpos         (display_hpos),
        .display_vpos         (display_vpos),
        .pixel_out            (pixel_out),
        .sram_cs_n            (sram_cs_n),
        .sram_sck             (sram_sck),
        .sram_sio_oe          (sram_sio_oe),
        .sram_sio0_i          (sio_i[0]),
        .sram_sio1_i          (sio_i[1]),
        .sram_sio2_i          (sio_i[2]),
        .sram_sio3_i          (sio_i[3]),
        .sram_sio0_o          (sram_sio0_o),
        .sram_sio1_o          (sram_sio1_o),
        .sram_sio2_o          (sram_sio2_o),
        .sram_sio3_o          (sram_sio3_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // SRAM model: byte-addressed memory, single-bit mode until EQIO, then quad reads
    logic [7:0]  mem [0:16383];
    logic [7:0]  eqio_q [$];
    logic [31:0] hdr_q [$];
    bit          quad;
    int          bitn;
    int          nibn;
    logic [7:0]  sbyte;
    logic [31:0] hdr;
    logic        sck_q;

    always @(negedge clk) begin
        if (!reset) begin
            quad  = 0;
            bitn  = 0;
            nibn  = 0;
            sck_q = 1'b0;
            sio_i = 4'h0;
        end else if (sram_cs_n) begin
            bitn  = 0;
            nibn  = 0;
            sck_q = sram_sck;
        end else begin
            if (sram_sck && !sck_q) begin
                if (!quad) begin
                    sbyte = {sbyte[6:0], sram_sio0_o};
                    bitn++;
                    if (bitn == 8) begin
                        eqio_q.push_back(sbyte);
                        if (sbyte == 8'h38) quad = 1;
                    end
                end else begin
                    if (nibn < 8) hdr = {hdr[27:0], sram_sio3_o, sram_sio2_o, sram_sio1_o, sram_sio0_o};
                    nibn++;
                    if (nibn == 8) hdr_q.push_back(hdr);
                end
            end else if (!sram_sck && sck_q && quad && nibn >= 10) begin
                logic [7:0] b;
                int idx;
                idx = nibn - 10;
                b = mem[(int'(hdr[23:0]) + idx / 2) % 16384];
                sio_i = (idx % 2 == 0) ? b[7:4] : b[3:0];
            end
            sck_q = sram_sck;
        end
    end

    function automatic logic ref_pix(input int line, input int h);
        logic [7:0] b;
        b = mem[line * 64 + h / 8];
        return b[7 - h % 8];
    endfunction

    bit model_init = 0;
    int shown      = -1;
    bit pend       = 0;
    int hdr_rd     = 0;

    task automatic run_line(input int v);
        logic [639:0] obs;
        logic [639:0] expv;
        int  oe_viol;
        int  cs_viol;
        bit  acc;
        bit  chk_pix;
        int  line;
        oe_viol = 0;
        cs_viol = 0;
        line    = (v == 524) ? 0 : v + 1;
        acc     = model_init && (line < 256);
        chk_pix = (v >= 256) || (shown == v);
        for (int h = 0; h < 800; h++) begin
            @(posedge clk);
            #1;
            display_hpos         = 10'(h);
            display_vpos         = 10'(v);
            display_active       = (h < 640) && (v < 480);
            display_trigger_read = (h == 752);
            @(negedge clk);
            if (h < 640) begin
                obs[h]  = pixel_out;
                expv[h] = (v < 256 && h < 512 && shown >= 0) ? ref_pix(shown, h) : 1'b0;
            end
            if (display_active && v < 256 && sram_sio_oe) oe_viol++;
            if (pend && h == 504) check("cs_hold_last_nibble", 64'(sram_cs_n), 64'd0);
            if (pend && h == 505) check("cs_rise_t553", 64'(sram_cs_n), 64'd1);
            if (h == 753) check("cs_after_trigger", 64'(sram_cs_n), 64'(!acc));
            if (acc && h == 784) check("oe_last_addr", 64'(sram_sio_oe), 64'd1);
            if (acc && h == 785) check("oe_dummy", 64'(sram_sio_oe), 64'd0);
            if (!acc && h >= 753 && !sram_cs_n) cs_viol++;
        end
        for (int c = 0; c < 10; c++)
            if (chk_pix || c >= 8) check($sformatf("pix_v%0d_c%0d", v, c), obs[c*64 +: 64], expv[c*64 +: 64]);
        check("oe_in_visible", 64'(oe_viol), 64'd0);
        if (acc) begin
            check("hdr_count", 64'(hdr_q.size() - hdr_rd), 64'd1);
            if (hdr_q.size() > hdr_rd) begin
                check($sformatf("hdr_line%0d", line), 64'(hdr_q[hdr_rd]), 64'({8'h03, 24'(line * 64)}));
                hdr_rd++;
            end
            shown = line;
        end else begin
            check("cs_idle_ignored", 64'(cs_viol), 64'd0);
            check("hdr_none", 64'(hdr_q.size() - hdr_rd), 64'd0);
        end
        pend = acc;
    endtask

    initial begin
        logic [7:0] eq;
        int  viol;
        int  r;
        int  neq;
        eq = 8'h38;
        reset = 1'b0;
        display_trigger_read = 1'b0;
        display_active = 1'b0;
        display_hpos = '0;
        display_vpos = '0;
        for (int i = 0; i < 16384; i++) mem[i] = (i < 64) ? 8'hAA : 8'($urandom);

        repeat (3) @(negedge clk);
        check("rst_cs_n", 64'(sram_cs_n), 64'd1);
        check("rst_sck", 64'(sram_sck), 64'd0);
        check("rst_oe", 64'(sram_sio_oe), 64'd0);
        check("rst_sio_o", 64'({sram_sio3_o, sram_sio2_o, sram_sio1_o, sram_sio0_o}), 64'd0);
        check("rst_initialized", 64'(initialized), 64'd0);
        check("rst_pixel", 64'(pixel_out), 64'd0);

        // cycle n is the n-th posedge after release; the sequence starts on n=1
        @(posedge clk);
        #1 reset = 1'b1;
        viol = 0;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            display_active       = 1'b1;
            display_vpos         = 10'd0;
            display_hpos         = 10'(n);
            display_trigger_read = (n == 34);
            @(negedge clk);
            if (n <= 32) begin
                if (sram_cs_n !== 1'b0 || sram_sio_oe !== 1'b1 || sram_sio2_o !== 1'b1 || sram_sio3_o !== 1'b1 ||
                    sram_sck !== (((n - 1) % 4) >= 2) || sram_sio0_o !== eq[7 - (n - 1) / 4]) viol++;
            end else if (sram_cs_n !== 1'b1 || sram_sck !== 1'b0) begin
                viol++;
            end
            if (n <= 36 && pixel_out !== 1'b0) viol++;
            if (n == 36) check("init_low_at_36", 64'(initialized), 64'd0);
            if (n == 37) check("init_high_at_37", 64'(initialized), 64'd1);
        end
        display_trigger_read = 1'b0;
        display_active       = 1'b0;
        check("init_sequence", 64'(viol), 64'd0);
        check("eqio_count", 64'(eqio_q.size()), 64'd1);
        if (eqio_q.size() > 0) check("eqio_byte", 64'(eqio_q[0]), 64'h38);
        check("early_trigger_ignored", 64'(hdr_q.size()), 64'd0);
        model_init = 1;

        r = $urandom_range(2, 252);
        run_line(524);
        run_line(0);
        run_line(1);
        run_line(9);
        run_line(10);
        run_line(r);
        run_line(r + 1);
        run_line(254);
        run_line(255);
        run_line(256);
        run_line(300);

        // abort a read at T+100 and expect a clean re-initialisation
        @(posedge clk);
        #1;
        display_active       = 1'b0;
        display_vpos         = 10'd524;
        display_trigger_read = 1'b1;
        @(posedge clk);
        #1 display_trigger_read = 1'b0;
        repeat (98) @(posedge clk);
        @(negedge clk);
        check("abort_mid_read_cs", 64'(sram_cs_n), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_cs_n", 64'(sram_cs_n), 64'd1);
        check("abort_initialized", 64'(initialized), 64'd0);
        check("abort_oe", 64'(sram_sio_oe), 64'd0);
        check("abort_sck", 64'(sram_sck), 64'd0);
        check("abort_hdr_count", 64'(hdr_q.size() - hdr_rd), 64'd1);
        if (hdr_q.size() > hdr_rd) begin
            check("abort_hdr", 64'(hdr_q[hdr_rd]), 64'h03000000);
            hdr_rd++;
        end
        neq = eqio_q.size();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("reinit_initialized", 64'(initialized), 64'd1);
        check("reinit_eqio_count", 64'(eqio_q.size() - neq), 64'd1);
        if (eqio_q.size() > neq) check("reinit_eqio_byte", 64'(eqio_q[neq]), 64'h38);
        shown = -1;
        pend  = 0;
        run_line(524);
        run_line(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
